// File: rtl/fir_band_mac_scheduler.sv
// Sequencer for a shared-MAC four-band FIR bank: writes each new sample into
// history, then walks every tap of every enabled band through one MAC.
module fir_band_mac_scheduler #(
  parameter int NTAPS = 32,
  parameter int TAP_W = 5,
  parameter int DW    = 16
) (
  input  logic             clk_slow,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [DW-1:0]    sample_in,
  input  logic [3:0]       band_en,
  output logic             hist_we,
  output logic [TAP_W-1:0] hist_waddr,
  output logic [DW-1:0]    hist_wdata,
  output logic [TAP_W-1:0] hist_raddr,
  output logic [1:0]       coef_band,
  output logic [TAP_W-1:0] coef_tap,
  output logic             mac_en,
  output logic             mac_clr,
  output logic             acc_done,
  output logic [1:0]       acc_band,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [2:0] {IDLE, WR, ISSUE, DRAIN, DONE} state_t;

  state_t           r_state;
  logic [3:0]       r_mask;
  logic [1:0]       r_band;
  logic [TAP_W-1:0] r_wr_ptr;
  logic             r_issue;

  logic [3:0]       w_rem;
  logic [1:0]       w_first_band;
  logic [1:0]       w_next_band;
  logic             w_last_tap;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign w_rem        = r_mask & ~(4'b0001 << r_band);
  assign w_first_band = lowest_set(r_mask);
  assign w_next_band  = lowest_set(w_rem);
  assign w_last_tap   = (coef_tap == TAP_W'(NTAPS - 1));

  always_ff @(posedge clk_slow or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_mask     <= '0;
      r_band     <= '0;
      r_wr_ptr   <= '0;
      r_issue    <= 1'b0;
      hist_we    <= 1'b0;
      hist_waddr <= '0;
      hist_wdata <= '0;
      hist_raddr <= '0;
      coef_band  <= '0;
      coef_tap   <= '0;
      mac_en     <= 1'b0;
      mac_clr    <= 1'b0;
      acc_done   <= 1'b0;
      acc_band   <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      hist_we  <= 1'b0;
      acc_done <= 1'b0;
      // RAM/ROM answer one cycle after the address, so the MAC trails issue by one
      mac_en   <= r_issue;
      mac_clr  <= r_issue && (coef_tap == '0);
      if (sample_valid && (r_state != IDLE)) overrun <= 1'b1;

      case (r_state)
        IDLE: begin
          if (sample_valid) begin
            r_state    <= WR;
            busy       <= 1'b1;
            hist_we    <= 1'b1;
            hist_waddr <= r_wr_ptr;
            hist_wdata <= sample_in;
            r_mask     <= band_en;
          end
        end
        WR: begin
          if (r_mask != '0) begin
            r_state    <= ISSUE;
            r_band     <= w_first_band;
            coef_band  <= w_first_band;
            coef_tap   <= '0;
            hist_raddr <= r_wr_ptr;
            r_issue    <= 1'b1;
          end else begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_state  <= IDLE;
            busy     <= 1'b0;
          end
        end
        ISSUE: begin
          if (w_last_tap) begin
            r_issue <= 1'b0;
            r_state <= DRAIN;
          end else begin
            coef_tap   <= coef_tap + 1'b1;
            hist_raddr <= hist_raddr - 1'b1;
          end
        end
        DRAIN: begin
          r_state  <= DONE;
          acc_done <= 1'b1;
          acc_band <= r_band;
        end
        DONE: begin
          r_mask <= w_rem;
          if (w_rem != '0) begin
            r_state    <= ISSUE;
            r_band     <= w_next_band;
            coef_band  <= w_next_band;
            coef_tap   <= '0;
            hist_raddr <= r_wr_ptr;
            r_issue    <= 1'b1;
          end else begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_state  <= IDLE;
            busy     <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_band_mac_scheduler.sv
// Bench for fir_band_mac_scheduler: frame-offset reference model checked every
// cycle, plus literal timing/count expectations from the directed scenarios.
module tb_fir_band_mac_scheduler;
  localparam int NT = 32;
  localparam int TW = 5;
  localparam int DW = 16;

  logic          clk_slow = 1'b0;
  logic          rst = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic [3:0]    band_en = '0;
  logic          hist_we;
  logic [TW-1:0] hist_waddr;
  logic [DW-1:0] hist_wdata;
  logic [TW-1:0] hist_raddr;
  logic [1:0]    coef_band;
  logic [TW-1:0] coef_tap;
  logic          mac_en, mac_clr, acc_done;
  logic [1:0]    acc_band;
  logic          busy, overrun;

  fir_band_mac_scheduler #(.NTAPS(NT), .TAP_W(TW), .DW(DW)) dut (
    .clk_slow(clk_slow), .rst(rst), .sample_valid(sample_valid),
    .sample_in(sample_in), .band_en(band_en), .hist_we(hist_we),
    .hist_waddr(hist_waddr), .hist_wdata(hist_wdata), .hist_raddr(hist_raddr),
    .coef_band(coef_band), .coef_tap(coef_tap), .mac_en(mac_en),
    .mac_clr(mac_clr), .acc_done(acc_done), .acc_band(acc_band),
    .busy(busy), .overrun(overrun));

  always #5 clk_slow = ~clk_slow;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model (frame offset arithmetic) ----------------
  int m_active = 0, m_d = 0, m_n = 0, m_wp = 0, m_rel = 0;
  logic [3:0] m_mask = '0;
  int e_we = 0, e_waddr = 0, e_wdata = 0, e_raddr = 0, e_cband = 0, e_ctap = 0;
  int e_mac = 0, e_clr = 0, e_done = 0, e_aband = 0, e_busy = 0, e_ovr = 0;

  // observed per-frame statistics, cleared when a frame is accepted
  int s_we_n, s_we_d, s_waddr, s_mac_n, s_mac_first, s_clr_n, s_clr_first;
  int s_done_n, s_busy_n, s_bad_band, s_ovr_first;
  int s_done_d [4];
  int s_done_b [4];
  int s_raddr [NT];
  int s_ctap  [NT];

  function automatic int nth_band(input logic [3:0] m, input int j);
    int c = 0;
    for (int i = 0; i < 4; i++)
      if (m[i]) begin
        if (c == j) return i;
        c++;
      end
    return 0;
  endfunction

  always @(posedge clk_slow or posedge rst) begin
    if (rst) begin
      m_active = 0; m_d = 0; m_wp = 0; m_mask = '0;
      e_we = 0; e_waddr = 0; e_wdata = 0; e_raddr = 0; e_cband = 0; e_ctap = 0;
      e_mac = 0; e_clr = 0; e_done = 0; e_aband = 0; e_busy = 0; e_ovr = 0;
    end else begin
      int was_busy;
      was_busy = m_active;
      m_rel++;
      if (m_active != 0) begin
        m_d++;
        if (m_d > 1 + m_n * (NT + 2)) begin
          m_active = 0;
          m_wp = (m_wp + 1) % NT;
        end
      end
      e_we = 0; e_mac = 0; e_clr = 0; e_done = 0;
      if (sample_valid) begin
        if (was_busy != 0) e_ovr = 1;
        else begin
          m_active = 1; m_d = 1; m_rel = 1;
          m_mask = band_en; m_n = $countones(band_en);
          e_waddr = m_wp; e_wdata = int'(sample_in);
          s_we_n = 0; s_we_d = 0; s_waddr = -1; s_mac_n = 0; s_mac_first = 0;
          s_clr_n = 0; s_clr_first = 0; s_done_n = 0; s_busy_n = 0;
          s_bad_band = 0; s_ovr_first = 0;
        end
      end
      e_busy = m_active;
      if (m_active != 0) begin
        if (m_d == 1) e_we = 1;
        else begin
          int k, j, r, b;
          k = m_d - 2; j = k / (NT + 2); r = k % (NT + 2);
          b = nth_band(m_mask, j);
          if (r < NT) begin
            e_raddr = (m_wp - r + NT) % NT; e_cband = b; e_ctap = r;
          end
          if (r >= 1 && r <= NT) begin
            e_mac = 1; e_clr = (r == 1) ? 1 : 0;
          end
          if (r == NT + 1) begin
            e_done = 1; e_aband = b;
          end
        end
      end
    end
  end

  // ---------------- compare + statistics ----------------
  always @(negedge clk_slow) begin
    chk("hist_we",    32'(hist_we),    32'(e_we));
    chk("hist_waddr", 32'(hist_waddr), 32'(e_waddr));
    chk("hist_wdata", 32'(hist_wdata), 32'(e_wdata));
    chk("hist_raddr", 32'(hist_raddr), 32'(e_raddr));
    chk("coef_band",  32'(coef_band),  32'(e_cband));
    chk("coef_tap",   32'(coef_tap),   32'(e_ctap));
    chk("mac_en",     32'(mac_en),     32'(e_mac));
    chk("mac_clr",    32'(mac_clr),    32'(e_clr));
    chk("acc_done",   32'(acc_done),   32'(e_done));
    chk("acc_band",   32'(acc_band),   32'(e_aband));
    chk("busy",       32'(busy),       32'(e_busy));
    chk("overrun",    32'(overrun),    32'(e_ovr));
    if (hist_we) begin s_we_n++; s_we_d = m_rel; s_waddr = int'(hist_waddr); end
    if (mac_en) begin s_mac_n++; if (s_mac_first == 0) s_mac_first = m_rel; end
    if (mac_clr) begin s_clr_n++; if (s_clr_first == 0) s_clr_first = m_rel; end
    if (acc_done) begin
      if (s_done_n < 4) begin s_done_d[s_done_n] = m_rel; s_done_b[s_done_n] = int'(acc_band); end
      s_done_n++;
    end
    if (busy) begin
      s_busy_n++;
      if (!coef_band[0]) s_bad_band++;
    end
    if (m_rel >= 2 && m_rel <= NT + 1) begin
      s_raddr[m_rel-2] = int'(hist_raddr);
      s_ctap[m_rel-2]  = int'(coef_tap);
    end
    if (overrun && s_ovr_first == 0) s_ovr_first = m_rel;
  end

  // ---------------- stimulus ----------------
  task automatic run_frame(input logic [3:0] m, input int ovr_d, input int tail);
    int L;
    L = 1 + $countones(m) * (NT + 2);
    sample_valid = 1'b1; band_en = m; sample_in = 16'($urandom);
    @(posedge clk_slow); #1;
    sample_valid = 1'b0; band_en = 4'($urandom);
    for (int d = 1; d <= L + tail; d++) begin
      sample_valid = (d == ovr_d);
      sample_in = 16'($urandom);
      @(posedge clk_slow); #1;
    end
    sample_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " hist_we"}, 32'(hist_we), 0);
    chk({tag, " hist_waddr"}, 32'(hist_waddr), 0);
    chk({tag, " hist_wdata"}, 32'(hist_wdata), 0);
    chk({tag, " hist_raddr"}, 32'(hist_raddr), 0);
    chk({tag, " coef_band"}, 32'(coef_band), 0);
    chk({tag, " coef_tap"}, 32'(coef_tap), 0);
    chk({tag, " mac_en"}, 32'(mac_en), 0);
    chk({tag, " mac_clr"}, 32'(mac_clr), 0);
    chk({tag, " acc_done"}, 32'(acc_done), 0);
    chk({tag, " acc_band"}, 32'(acc_band), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " overrun"}, 32'(overrun), 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 chk_all_zero("reset");
    repeat (2) @(posedge clk_slow);
    #1 rst = 1'b0;
    @(posedge clk_slow); #1;

    // all four bands, wr_ptr 0
    run_frame(4'b1111, 0, 2);
    chk("f1111 done_n", s_done_n, 4);
    for (int i = 0; i < 4; i++) begin
      chk("f1111 done_cycle", s_done_d[i], 35 + 34 * i);
      chk("f1111 done_band", s_done_b[i], i);
    end
    chk("f1111 mac_n", s_mac_n, 128);
    chk("f1111 clr_n", s_clr_n, 4);
    chk("f1111 busy_n", s_busy_n, 137);
    chk("f1111 we_cycle", s_we_d, 1);
    chk("f1111 waddr", s_waddr, 0);

    // bands 1 and 3, wr_ptr 1
    run_frame(4'b1010, 0, 1);
    chk("f1010 done_n", s_done_n, 2);
    chk("f1010 done0", s_done_d[0], 35);
    chk("f1010 band0", s_done_b[0], 1);
    chk("f1010 done1", s_done_d[1], 69);
    chk("f1010 band1", s_done_b[1], 3);
    chk("f1010 even_band", s_bad_band, 0);
    chk("f1010 busy_n", s_busy_n, 69);
    chk("f1010 waddr", s_waddr, 1);

    // no bands, wr_ptr 2
    run_frame(4'b0000, 0, 1);
    chk("f0000 we_n", s_we_n, 1);
    chk("f0000 we_cycle", s_we_d, 1);
    chk("f0000 mac_n", s_mac_n, 0);
    chk("f0000 done_n", s_done_n, 0);
    chk("f0000 busy_n", s_busy_n, 1);

    // address wrap with wr_ptr 3
    run_frame(4'b0001, 0, 1);
    chk("wrap waddr", s_waddr, 3);
    chk("wrap raddr0", s_raddr[0], 3);
    chk("wrap raddr3", s_raddr[3], 0);
    chk("wrap raddr4", s_raddr[4], 31);
    chk("wrap raddr31", s_raddr[31], 4);
    for (int k = 0; k < NT; k++) chk("wrap coef_tap", s_ctap[k], k);
    chk("wrap mac_first", s_mac_first, 3);
    chk("wrap clr_first", s_clr_first, 3);

    // overrun during a four-band frame, then a normal frame
    run_frame(4'b1111, 50, 1);
    chk("ovr first", s_ovr_first, 51);
    chk("ovr done_n", s_done_n, 4);
    run_frame(4'b0100, 0, 1);
    chk("ovr next done_n", s_done_n, 1);
    chk("ovr next band", s_done_b[0], 2);
    chk("ovr sticky", 32'(overrun), 1);

    // randomized frames, including back-to-back and stray samples
    for (int f = 0; f < 12; f++) begin
      logic [3:0] m;
      int L, od;
      m = 4'($urandom_range(0, 15));
      L = 1 + $countones(m) * (NT + 2);
      od = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, L)) : 0;
      run_frame(m, od, int'($urandom_range(0, 2)));
    end

    // asynchronous reset in the middle of ISSUE
    sample_valid = 1'b1; band_en = 4'b1111; sample_in = 16'h1234;
    @(posedge clk_slow); #1;
    sample_valid = 1'b0;
    repeat (19) begin @(posedge clk_slow); #1; end
    #3 rst = 1'b1;
    #1 chk_all_zero("midreset");
    @(posedge clk_slow); #1 rst = 1'b0;
    run_frame(4'b1111, 0, 1);
    chk("postrst waddr", s_waddr, 0);
    chk("postrst done0", s_done_d[0], 35);
    chk("postrst ovr", 32'(overrun), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_band_mac_scheduler.md
Name: fir_band_mac_scheduler

Overview:
- Sequencer for a shared-MAC EEG filter bank. It time-multiplexes one multiply-accumulate engine, one sample-history RAM and one coefficient ROM across the four bands: delta=0, theta=1, alpha=2, beta=3.
- For each accepted 16-bit input sample it writes the sample into history, then issues every tap of every enabled band.
- It generates RAM/ROM addresses, MAC control and per-band completion strobes, replacing four parallel FIR instances with one datapath on clk_slow.

Parameters:
- NTAPS, 32, taps per band; power of two, ≥4.
- TAP_W, 5, log2(NTAPS); width of tap and history addresses.
- DW, 16, sample width.

Ports:
- clk_slow  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample_valid  in  1  one-cycle strobe; sample_in is valid.
- sample_in  in  DW  new input sample.
- band_en  in  4  band enable mask, bit i enables band i.
- hist_we  out  1  history RAM write enable.
- hist_waddr  out  TAP_W  history write address.
- hist_wdata  out  DW  history write data.
- hist_raddr  out  TAP_W  history read address; RAM has 1-cycle read latency.
- coef_band  out  2  coefficient ROM bank select; ROM has 1-cycle latency.
- coef_tap  out  TAP_W  coefficient index.
- mac_en  out  1  MAC accumulates this cycle; aligned with RAM/ROM data.
- mac_clr  out  1  with mac_en: accumulator loads product instead of adding.
- acc_done  out  1  one-cycle strobe; accumulator holds the finished band result.
- acc_band  out  2  band index qualifying acc_done.
- busy  out  1  high whenever state ≠ IDLE.
- overrun  out  1  sticky; a sample arrived while busy.

Behaviour:
- All outputs are registered.
- Reset (async, any state) forces: state=IDLE; wr_ptr=0; all outputs 0, including overrun. History RAM contents are not cleared.
- States: IDLE, WR, ISSUE, DRAIN, DONE.
- IDLE:
  - On sample_valid, latch sample_in, and latch band_en into mask.
  - Go to WR. band_en changes after this edge have no effect until the next sample.
- WR (1 cycle):
  - hist_we=1, hist_waddr=wr_ptr, hist_wdata=latched sample.
  - If mask≠0: band=lowest set bit of mask, tap=0, go to ISSUE.
  - If mask=0: wr_ptr←wr_ptr+1 mod NTAPS, go to IDLE.
- ISSUE (NTAPS cycles, tap k=0..NTAPS-1):
  - hist_raddr=(wr_ptr−k) mod NTAPS; coef_band=band; coef_tap=k.
  - After k=NTAPS-1, go to DRAIN.
- MAC alignment:
  - mac_en is the issue-valid signal delayed by 1 cycle.
  - mac_clr is asserted only together with the mac_en of tap 0.
  - The mac_en of the last tap falls in DRAIN.
- DRAIN (1 cycle): go to DONE.
- DONE (1 cycle):
  - acc_done=1, acc_band=band. Clear band's bit in mask.
  - If the remaining mask≠0: next band = lowest set bit, tap=0, go to ISSUE.
  - Otherwise: wr_ptr←wr_ptr+1 mod NTAPS, go to IDLE.
- Timing:
  - Per enabled band: NTAPS+2 cycles.
  - Total busy time: 1+n_en·(NTAPS+2) cycles.
  - Bands are processed in ascending index order.
- Wrap-around: hist_raddr and wr_ptr wrap modulo NTAPS; no special case is needed at 0.
- Overrun:
  - sample_valid while busy=1 is dropped and sets overrun=1 on the next edge.
  - The in-flight frame continues unaffected; overrun clears only on rst.
- Back-to-back: sample_valid in the same cycle the FSM returns to IDLE is accepted (IDLE is the state on that edge). sample_valid during DONE counts as overrun.
- Idle values: hist_we, mac_en, mac_clr and acc_done are 0 outside the cycles stated above. Address outputs hold their last value.

Test Plan:
- NTAPS=32, band_en=4'b1111, one sample accepted at edge 0:
  - hist_we at cycle 1.
  - acc_done with acc_band 0,1,2,3 at cycles 35, 69, 103, 137.
  - busy high cycles 1–137; IDLE at 138.
  - Exactly 128 mac_en pulses and 4 mac_clr pulses.
- band_en=4'b1010: acc_done band1 at cycle 35 and band3 at cycle 69 only; coef_band never 0 or 2; busy 69 cycles.
- band_en=4'b0000: one hist_we at cycle 1, no mac_en or acc_done, busy for 1 cycle. The next sample writes hist_waddr=1.
- Address wrap, after 3 prior frames (wr_ptr=3):
  - hist_raddr sequence is 3,2,1,0,31,30,…,4.
  - coef_tap is 0..31.
  - mac_clr coincides with the first mac_en, one cycle after the first issue.
- Overrun: sample_valid at cycle 50 of a 4-band frame.
  - overrun=1 from cycle 51 and stays set.
  - Still exactly 4 acc_done pulses.
  - A later in-IDLE sample is processed normally; overrun stays 1.
- Async reset mid-ISSUE at cycle 20:
  - All outputs 0 immediately, without waiting for a clock edge.
  - The next accepted sample writes hist_waddr=0, and the first acc_done arrives 35 cycles after acceptance.
